// File: rtl/picosoc_irq_timer_if.sv
// picorv32 native memory bus as seen by a single slave peripheral.
interface picosoc_irq_timer_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picosoc_irq_timer.sv
// Interrupt controller plus machine timer for picosoc.
// PENDING[31:4] latch synchronized rising edges of ext_irq, PENDING[3] is the
// timer compare event, and irq is the registered PENDING & ENABLE.
module picosoc_irq_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    picosoc_irq_timer_if.slave   bus,
    input  logic [27:0]          ext_irq,
    output logic [31:0]          irq,
    input  logic [31:0]          eoi
);
    // Arming counter: edge detection stays off until the synchronizer and the
    // edge flop hold real post-reset samples, so a line held high through
    // reset release is not mistaken for a new edge.
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic                         ready_q, ready_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [31:0]                  pending_q, pending_d;
    logic [31:0]                  enable_q, enable_d;
    logic [31:0]                  mtime_q, mtime_d;
    logic [31:0]                  mtimecmp_q, mtimecmp_d;
    logic [15:0]                  prescale_q, prescale_d;
    logic [15:0]                  pcnt_q, pcnt_d;
    logic                         tick_q, tick_d;
    logic [31:0]                  irq_q, irq_d;
    logic [31:0]                  eoi_q, eoi_d;
    logic [SYNC_STAGES-1:0][27:0] sync_q, sync_d;
    logic [27:0]                  prev_q, prev_d;
    logic [ARM_W-1:0]             arm_q, arm_d;

    logic        sel, wr, rd, armed, hit;
    logic [31:0] wmask, wmerge_en, wmerge_mt, wmerge_cmp, wset;
    logic [27:0] edge_v;
    logic [31:0] set_v, clr_v;

    // Bus decode, register updates, timer and interrupt bookkeeping.
    always_comb begin
        sel   = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]) && !ready_q;
        wr    = sel && (bus.mem_wstrb != 4'b0000);
        rd    = sel && (bus.mem_wstrb == 4'b0000);
        wmask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                 {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
        wset       = bus.mem_wdata & wmask;
        wmerge_en  = (enable_q   & ~wmask) | wset;
        wmerge_mt  = (mtime_q    & ~wmask) | wset;
        wmerge_cmp = (mtimecmp_q & ~wmask) | wset;

        ready_d    = sel;
        enable_d   = enable_q;
        mtimecmp_d = mtimecmp_q;
        prescale_d = prescale_q;
        eoi_d      = eoi;
        prev_d     = sync_q[SYNC_STAGES-1];
        irq_d      = pending_q & enable_q;

        sync_d[0] = ext_irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        armed  = (arm_q == ARM_W'(ARM_MAX));
        arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
        edge_v = sync_q[SYNC_STAGES-1] & ~prev_q & {28{armed}};

        // The compare event only counts when the counter itself moved MTIME
        // onto MTIMECMP; software writes leave tick_q low.
        hit = tick_q && (mtime_q == mtimecmp_q);

        if (wr && bus.mem_addr[7:0] == 8'h08) begin
            mtime_d = wmerge_mt;
            pcnt_d  = 16'd0;
            tick_d  = 1'b0;
        end else if (pcnt_q >= prescale_q) begin
            // >= so that lowering PRESCALE below the running count ticks at once
            mtime_d = mtime_q + 32'd1;
            pcnt_d  = 16'd0;
            tick_d  = 1'b1;
        end else begin
            mtime_d = mtime_q;
            pcnt_d  = pcnt_q + 16'd1;
            tick_d  = 1'b0;
        end

        set_v = {edge_v, 4'b0000} | {28'd0, hit, 3'b000};
        clr_v = eoi & ~eoi_q;
        if (wr && bus.mem_addr[7:0] == 8'h14) set_v = set_v | wset;
        if (wr && bus.mem_addr[7:0] == 8'h00) clr_v = clr_v | wset;
        pending_d = ((pending_q & ~clr_v) | set_v) & ~32'h7;

        if (wr && bus.mem_addr[7:0] == 8'h04) enable_d   = wmerge_en & ~32'h7;
        if (wr && bus.mem_addr[7:0] == 8'h0C) mtimecmp_d = wmerge_cmp;
        if (wr && bus.mem_addr[7:0] == 8'h10)
            prescale_d = (prescale_q & ~wmask[15:0]) | wset[15:0];

        rdata_d = 32'd0;
        if (rd) begin
            case (bus.mem_addr[7:0])
                8'h00:   rdata_d = pending_q;
                8'h04:   rdata_d = enable_q;
                8'h08:   rdata_d = mtime_q;
                8'h0C:   rdata_d = mtimecmp_q;
                8'h10:   rdata_d = {16'd0, prescale_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    // State registers, all cleared asynchronously so an access in flight is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            pending_q  <= 32'd0;
            enable_q   <= 32'd0;
            mtime_q    <= 32'd0;
            mtimecmp_q <= 32'hFFFF_FFFF;
            prescale_q <= 16'd0;
            pcnt_q     <= 16'd0;
            tick_q     <= 1'b0;
            irq_q      <= 32'd0;
            eoi_q      <= 32'd0;
            sync_q     <= '0;
            prev_q     <= 28'd0;
            arm_q      <= '0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            eoi_q      <= eoi_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            arm_q      <= arm_d;
        end
    end

    // rdata_q is only non-zero in the ready cycle, so it can be OR-combined.
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_picosoc_irq_timer.sv
// Bench for picosoc_irq_timer: directed scenarios with literal expectations,
// then randomized bus/interrupt traffic checked every cycle against a model.
module tb_picosoc_irq_timer;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          S    = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [27:0] ext_irq = '0;
    logic [31:0] eoi = '0;
    logic [31:0] irq;

    picosoc_irq_timer_if bus_if ();

    picosoc_irq_timer #(.BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .bus(bus_if.slave),
        .ext_irq(ext_irq), .irq(irq), .eoi(eoi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    logic [31:0] m_pend, m_en, m_mtime, m_cmp, m_pre, m_irq, m_rdata, m_eoi_prev;
    int          m_pcnt;
    bit          m_tickd, m_ready;
    logic [27:0] samp[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] st);
        return {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_mtime = 0; m_cmp = 32'hFFFF_FFFF; m_pre = 0;
        m_pcnt = 0; m_tickd = 0; m_irq = 0; m_ready = 0; m_rdata = 0;
        m_eoi_prev = 0;
        samp.delete();
    endtask

    // One clock edge of the register-level behaviour, from the inputs the bench drives.
    task automatic model_step();
        bit          sel, wr, rdn, hit, tk;
        logic [7:0]  off;
        logic [31:0] wd, mk, rv, setv, clrv, nmt;
        logic [27:0] edg;
        int          npc;
        sel = bus_if.mem_valid && (bus_if.mem_addr[31:8] == BASE[31:8]) && !m_ready;
        wr  = sel && (bus_if.mem_wstrb != 0);
        rdn = sel && (bus_if.mem_wstrb == 0);
        off = bus_if.mem_addr[7:0];
        mk  = smask(bus_if.mem_wstrb);
        wd  = bus_if.mem_wdata & mk;
        rv  = 0;
        if (rdn) begin
            if (off == 8'h00) rv = m_pend;
            if (off == 8'h04) rv = m_en;
            if (off == 8'h08) rv = m_mtime;
            if (off == 8'h0C) rv = m_cmp;
            if (off == 8'h10) rv = m_pre;
        end
        hit = m_tickd && (m_mtime == m_cmp);
        samp.push_back(ext_irq);
        if (samp.size() > S + 2) void'(samp.pop_front());
        edg = (samp.size() == S + 2) ? (samp[1] & ~samp[0]) : 28'd0;
        setv = {edg, 4'b0} | (hit ? 32'h8 : 32'h0) | ((wr && off == 8'h14) ? wd : 32'h0);
        clrv = (eoi & ~m_eoi_prev) | ((wr && off == 8'h00) ? wd : 32'h0);
        if (wr && off == 8'h08) begin
            nmt = (m_mtime & ~mk) | wd; npc = 0; tk = 0;
        end else if (m_pcnt >= int'(m_pre)) begin
            nmt = m_mtime + 1; npc = 0; tk = 1;
        end else begin
            nmt = m_mtime; npc = m_pcnt + 1; tk = 0;
        end
        m_irq   = m_pend & m_en;
        m_pend  = ((m_pend & ~clrv) | setv) & ~32'h7;
        m_mtime = nmt; m_pcnt = npc; m_tickd = tk;
        if (wr && off == 8'h04) m_en  = ((m_en & ~mk) | wd) & ~32'h7;
        if (wr && off == 8'h0C) m_cmp = (m_cmp & ~mk) | wd;
        if (wr && off == 8'h10) m_pre = ((m_pre & ~mk) | wd) & 32'h0000_FFFF;
        m_ready = sel; m_rdata = rv; m_eoi_prev = eoi;
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && resetn) begin
            check32("cyc_ready", {31'd0, bus_if.mem_ready}, {31'd0, m_ready});
            check32("cyc_rdata", bus_if.mem_rdata, m_rdata);
            check32("cyc_irq", irq, m_irq);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step();
        @(negedge clk);
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rdv);
        bus_if.mem_valid = 1'b1; bus_if.mem_addr = a;
        bus_if.mem_wdata = wd;   bus_if.mem_wstrb = st;
        tick();
        check32("ready_after_1", {31'd0, bus_if.mem_ready}, 32'd1);
        rdv = bus_if.mem_rdata;
        bus_if.mem_valid = 1'b0; bus_if.mem_wstrb = 4'b0;
        tick();
        check32("ready_one_cycle", {31'd0, bus_if.mem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] dummy;
        bus(BASE + off, wd, st, dummy);
    endtask

    task automatic rd_chk(input logic [31:0] off, input logic [31:0] exp, input string name);
        logic [31:0] v;
        bus(BASE + off, 32'd0, 4'b0, v);
        check32(name, v, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd_off, rnd_wd;
        logic [3:0]  rnd_st;
        int          r;
        bus_if.mem_valid = 0; bus_if.mem_addr = 0; bus_if.mem_wdata = 0; bus_if.mem_wstrb = 0;
        model_reset();
        #23;
        @(negedge clk);
        resetn = 1'b1;
        chk_en = 1'b1;

        // reset values
        rd_chk(32'h00, 32'h0, "rst_pending");
        rd_chk(32'h04, 32'h0, "rst_enable");
        rd_chk(32'h0C, 32'hFFFF_FFFF, "rst_mtimecmp");
        rd_chk(32'h10, 32'h0, "rst_prescale");

        // byte strobes and unmapped read
        wr(32'h04, 32'hAABB_CCDD, 4'b0010);
        rd_chk(32'h04, 32'h0000_CC00, "enable_byte_wr");
        rd_chk(32'h18, 32'h0, "unmapped_read");
        wr(32'h10, 32'hFFFF_0102, 4'b1111);
        rd_chk(32'h10, 32'h0000_0102, "prescale_upper_zero");
        wr(32'h10, 32'h0, 4'b1111);

        // external edge latency and eoi clear
        wr(32'h04, 32'h10, 4'b1111);
        ext_irq[0] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            check32($sformatf("ext_latency_%0d", j), irq, (j == 4) ? 32'h10 : 32'h0);
        end
        eoi = 32'h10;
        tick();
        tick();
        check32("eoi_irq_low", irq, 32'h0);
        rd_chk(32'h00, 32'h0, "eoi_pending_clr");
        eoi = 0; ext_irq = 0;
        repeat (4) tick();

        // W1C racing a new edge: set wins
        ext_irq[0] = 1'b1;
        tick(); tick();
        wr(32'h00, 32'h10, 4'b1111);
        rd_chk(32'h00, 32'h10, "w1c_vs_edge");
        wr(32'h00, 32'h10, 4'b1111);
        rd_chk(32'h00, 32'h0, "w1c_clear");
        ext_irq = 0;

        // prescaled timer compare
        wr(32'h04, 32'h8, 4'b1111);
        wr(32'h10, 32'h3, 4'b1111);
        wr(32'h0C, 32'h5, 4'b1111);
        wr(32'h08, 32'h0, 4'b1111);
        for (int k = 1; k <= 21; k++) begin
            tick();
            check32($sformatf("timer_irq_%0d", k), irq, (k == 21) ? 32'h8 : 32'h0);
        end
        rd_chk(32'h00, 32'h8, "timer_pending");
        wr(32'h00, 32'h8, 4'b1111);

        // wrap without compare event
        wr(32'h10, 32'h0, 4'b1111);
        wr(32'h0C, 32'hFFFF_FFFF, 4'b1111);
        wr(32'h08, 32'hFFFF_FFFF, 4'b1111);
        rd_chk(32'h08, 32'h0, "mtime_wrap");
        rd_chk(32'h00, 32'h0, "wrap_no_pending");

        // software set, then reset in the middle of an access
        wr(32'h04, 32'hFFFF_FFFF, 4'b1111);
        rd_chk(32'h04, 32'hFFFF_FFF8, "enable_low_bits_zero");
        wr(32'h14, 32'h0000_0107, 4'b0011);
        rd_chk(32'h00, 32'h0000_0100, "swset_pending");
        rd_chk(32'h14, 32'h0, "swset_reads_zero");
        check32("swset_irq", irq, 32'h0000_0100);
        bus_if.mem_valid = 1; bus_if.mem_addr = BASE + 32'h04;
        bus_if.mem_wdata = 32'h0000_0FF0; bus_if.mem_wstrb = 4'hF;
        @(posedge clk);
        model_step();
        #2;
        resetn = 1'b0;
        ext_irq = 28'h2;
        #1;
        check32("async_rst_ready", {31'd0, bus_if.mem_ready}, 32'd0);
        check32("async_rst_irq", irq, 32'h0);
        check32("async_rst_rdata", bus_if.mem_rdata, 32'h0);
        model_reset();
        bus_if.mem_valid = 0; bus_if.mem_wstrb = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) tick();
        rd_chk(32'h00, 32'h0, "held_high_no_edge");
        rd_chk(32'h04, 32'h0, "post_rst_enable");
        rd_chk(32'h0C, 32'hFFFF_FFFF, "post_rst_mtimecmp");
        wr(32'h04, 32'h0000_0FF0, 4'hF);
        rd_chk(32'h04, 32'h0000_0FF0, "reissued_write");
        ext_irq = 0;
        repeat (3) tick();
        ext_irq = 28'h2;
        repeat (4) tick();
        rd_chk(32'h00, 32'h20, "edge_after_reset");

        // randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 3) == 0) ext_irq = ext_irq ^ (28'd1 << $urandom_range(0, 27));
            eoi = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                case ($urandom_range(0, 8))
                    0: rnd_off = 32'h00; 1: rnd_off = 32'h04; 2: rnd_off = 32'h08;
                    3: rnd_off = 32'h0C; 4: rnd_off = 32'h10; 5: rnd_off = 32'h14;
                    6: rnd_off = 32'h18; 7: rnd_off = 32'h1C;
                    default: rnd_off = {24'd0, 8'($urandom_range(0, 255))};
                endcase
                rnd_st = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
                rnd_wd = $urandom;
                if ((rnd_off == 32'h08 || rnd_off == 32'h0C) && $urandom_range(0, 1) == 1)
                    rnd_wd = $urandom_range(0, 40);
                if (rnd_off == 32'h10) rnd_wd = $urandom_range(0, 5);
                wr(rnd_off, rnd_wd, rnd_st);
            end else if (r == 4) begin
                bus_if.mem_valid = 1; bus_if.mem_addr = BASE + 32'h100;
                bus_if.mem_wstrb = 4'hF; bus_if.mem_wdata = $urandom;
                tick(); tick();
                bus_if.mem_valid = 0; bus_if.mem_wstrb = 0;
                tick();
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
